// File: rtl/amba_axi4_stream_monitor.sv
// AXI4-Stream protocol monitor: passive observer that flags handshake and
// packet-framing violations and keeps saturating beat/packet/byte statistics.
module amba_axi4_stream_monitor #(
  parameter int DATA_WIDTH_BYTES = 4,
  parameter int ID_WIDTH         = 1,
  parameter int DEST_WIDTH       = 1,
  parameter int USER_WIDTH       = 1,
  parameter int MAX_STALL        = 16,
  parameter int MIN_PACKET       = 0,
  parameter int MAX_PACKET       = 0,
  parameter int CNT_WIDTH        = 32
) (
  input  logic                          ACLK,
  input  logic                          ARESETn,
  input  logic [8*DATA_WIDTH_BYTES-1:0] TDATA,
  input  logic [DATA_WIDTH_BYTES-1:0]   TSTRB,
  input  logic [DATA_WIDTH_BYTES-1:0]   TKEEP,
  input  logic                          TLAST,
  input  logic [ID_WIDTH-1:0]           TID,
  input  logic [DEST_WIDTH-1:0]         TDEST,
  input  logic [USER_WIDTH-1:0]         TUSER,
  input  logic                          TVALID,
  input  logic                          TREADY,
  output logic [7:0]                    err_pulse,
  output logic [7:0]                    err_sticky,
  output logic [CNT_WIDTH-1:0]          beat_count,
  output logic [CNT_WIDTH-1:0]          packet_count,
  output logic [CNT_WIDTH-1:0]          byte_count,
  output logic                          in_packet
);

  localparam int DW = 8 * DATA_WIDTH_BYTES;
  localparam int PW = DW + 2 * DATA_WIDTH_BYTES + 1 + ID_WIDTH + DEST_WIDTH + USER_WIDTH;
  localparam int KW = $clog2(DATA_WIDTH_BYTES + 1);
  localparam int SW = (MAX_STALL < 2) ? 1 : $clog2(MAX_STALL + 1);
  localparam int LW = CNT_WIDTH + 1;  // one spare bit so len/sums never wrap silently
  localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

  logic          hs;
  logic          stall;
  logic [PW-1:0] payload_now;
  logic [KW-1:0] keep_pop;
  logic [LW-1:0] len;
  logic [LW-1:0] byte_sum;
  logic [7:0]    err_now;

  logic                  rst_done_reg,     rst_done_next;
  logic [PW-1:0]         payload_reg;
  logic                  prev_stall_reg;
  logic [SW-1:0]         stall_cnt_reg,    stall_cnt_next;
  logic [CNT_WIDTH-1:0]  pkt_beats_reg,    pkt_beats_next;
  logic                  in_packet_reg,    in_packet_next;
  logic                  long_seen_reg,    long_seen_next;
  logic [ID_WIDTH-1:0]   id_reg,           id_next;
  logic [DEST_WIDTH-1:0] dest_reg,         dest_next;
  logic [7:0]            err_pulse_reg;
  logic [7:0]            err_sticky_reg,   err_sticky_next;
  logic [CNT_WIDTH-1:0]  beat_count_reg,   beat_count_next;
  logic [CNT_WIDTH-1:0]  packet_count_reg, packet_count_next;
  logic [CNT_WIDTH-1:0]  byte_count_reg,   byte_count_next;

  assign hs          = TVALID & TREADY;
  assign stall       = TVALID & ~TREADY;
  assign payload_now = {TDATA, TSTRB, TKEEP, TLAST, TID, TDEST, TUSER};

  // Number of kept bytes in the current beat.
  always_comb begin
    keep_pop = '0;
    for (int i = 0; i < DATA_WIDTH_BYTES; i++) begin
      keep_pop = keep_pop + KW'(TKEEP[i]);
    end
  end

  // Error detection and next-state for packet tracking and statistics.
  always_comb begin
    rst_done_next     = 1'b1;
    stall_cnt_next    = stall_cnt_reg;
    pkt_beats_next    = pkt_beats_reg;
    in_packet_next    = in_packet_reg;
    long_seen_next    = long_seen_reg;
    id_next           = id_reg;
    dest_next         = dest_reg;
    beat_count_next   = beat_count_reg;
    packet_count_next = packet_count_reg;
    byte_count_next   = byte_count_reg;

    len      = {1'b0, pkt_beats_reg} + LW'(1);
    byte_sum = {1'b0, byte_count_reg} + LW'(keep_pop);

    err_now[0] = prev_stall_reg & ~TVALID;
    err_now[1] = prev_stall_reg & TVALID & (payload_now != payload_reg);
    err_now[2] = TVALID & (|(TSTRB & ~TKEEP));
    err_now[3] = (MAX_STALL != 0) && stall && (stall_cnt_reg == SW'(MAX_STALL - 1));
    // Over-length is reported on the first beat past the limit; a TLAST beat
    // only reports it if the packet got there without a prior report.
    err_now[4] = (MAX_PACKET != 0) && hs && !long_seen_reg &&
                 (TLAST ? (len > LW'(MAX_PACKET)) : (len == LW'(MAX_PACKET + 1)));
    err_now[5] = (MIN_PACKET != 0) && hs && TLAST && (len < LW'(MIN_PACKET));
    err_now[6] = hs && in_packet_reg && ((TID != id_reg) || (TDEST != dest_reg));
    err_now[7] = !rst_done_reg && TVALID;

    err_sticky_next = err_sticky_reg | err_now;

    // Stall counter saturates so the timeout fires exactly once per stall.
    if (hs || !TVALID) begin
      stall_cnt_next = '0;
    end else if ((MAX_STALL != 0) && (stall_cnt_reg != SW'(MAX_STALL))) begin
      stall_cnt_next = stall_cnt_reg + 1'b1;
    end

    if (hs) begin
      if (!in_packet_reg) begin
        id_next   = TID;
        dest_next = TDEST;
      end
      if (TLAST) begin
        in_packet_next = 1'b0;
        pkt_beats_next = '0;
        long_seen_next = 1'b0;
        if (packet_count_reg != CNT_MAX) begin
          packet_count_next = packet_count_reg + 1'b1;
        end
      end else begin
        in_packet_next = 1'b1;
        pkt_beats_next = len[CNT_WIDTH] ? CNT_MAX : len[CNT_WIDTH-1:0];
        long_seen_next = long_seen_reg | err_now[4];
      end
      if (beat_count_reg != CNT_MAX) begin
        beat_count_next = beat_count_reg + 1'b1;
      end
      byte_count_next = byte_sum[CNT_WIDTH] ? CNT_MAX : byte_sum[CNT_WIDTH-1:0];
    end
  end

  // State register; everything clears while ARESETn is low.
  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      rst_done_reg     <= 1'b0;
      payload_reg      <= '0;
      prev_stall_reg   <= 1'b0;
      stall_cnt_reg    <= '0;
      pkt_beats_reg    <= '0;
      in_packet_reg    <= 1'b0;
      long_seen_reg    <= 1'b0;
      id_reg           <= '0;
      dest_reg         <= '0;
      err_pulse_reg    <= '0;
      err_sticky_reg   <= '0;
      beat_count_reg   <= '0;
      packet_count_reg <= '0;
      byte_count_reg   <= '0;
    end else begin
      rst_done_reg     <= rst_done_next;
      payload_reg      <= payload_now;
      prev_stall_reg   <= stall;
      stall_cnt_reg    <= stall_cnt_next;
      pkt_beats_reg    <= pkt_beats_next;
      in_packet_reg    <= in_packet_next;
      long_seen_reg    <= long_seen_next;
      id_reg           <= id_next;
      dest_reg         <= dest_next;
      err_pulse_reg    <= err_now;
      err_sticky_reg   <= err_sticky_next;
      beat_count_reg   <= beat_count_next;
      packet_count_reg <= packet_count_next;
      byte_count_reg   <= byte_count_next;
    end
  end

  assign err_pulse    = err_pulse_reg;
  assign err_sticky   = err_sticky_reg;
  assign beat_count   = beat_count_reg;
  assign packet_count = packet_count_reg;
  assign byte_count   = byte_count_reg;
  assign in_packet    = in_packet_reg;

endmodule

// File: tb/tb_amba_axi4_stream_monitor.sv
// Scoreboard bench: each driven cycle queues the err_pulse expected one cycle
// later; a negedge monitor pops and compares. Statistics checked at checkpoints.
module tb_amba_axi4_stream_monitor;

  localparam int DWB = 4;
  localparam int IDW = 2;
  localparam int CW  = 32;

  logic             ACLK = 1'b0;
  logic             ARESETn = 1'b0;
  logic [8*DWB-1:0] TDATA = '0;
  logic [DWB-1:0]   TSTRB = '0;
  logic [DWB-1:0]   TKEEP = '0;
  logic             TLAST = 1'b0;
  logic [IDW-1:0]   TID = '0;
  logic [0:0]       TDEST = '0;
  logic [0:0]       TUSER = '0;
  logic             TVALID = 1'b0;
  logic             TREADY = 1'b0;
  logic [7:0]       err_pulse;
  logic [7:0]       err_sticky;
  logic [CW-1:0]    beat_count;
  logic [CW-1:0]    packet_count;
  logic [CW-1:0]    byte_count;
  logic             in_packet;

  int n_vec  = 0;
  int n_miss = 0;
  logic [7:0] exp_q[$];

  amba_axi4_stream_monitor #(
    .DATA_WIDTH_BYTES(DWB), .ID_WIDTH(IDW), .DEST_WIDTH(1), .USER_WIDTH(1),
    .MAX_STALL(16), .MIN_PACKET(2), .MAX_PACKET(4), .CNT_WIDTH(CW)
  ) dut (
    .ACLK(ACLK), .ARESETn(ARESETn), .TDATA(TDATA), .TSTRB(TSTRB), .TKEEP(TKEEP),
    .TLAST(TLAST), .TID(TID), .TDEST(TDEST), .TUSER(TUSER), .TVALID(TVALID),
    .TREADY(TREADY), .err_pulse(err_pulse), .err_sticky(err_sticky),
    .beat_count(beat_count), .packet_count(packet_count), .byte_count(byte_count),
    .in_packet(in_packet)
  );

  always #5 ACLK = ~ACLK;

  task automatic expect_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
    end
  endtask

  // Monitor: compare the pulse produced for the previous edge.
  always @(negedge ACLK) begin
    if (exp_q.size() > 0) begin
      logic [7:0] e;
      e = exp_q.pop_front();
      $display("t=%0t err_pulse=0x%02h exp=0x%02h beats=%0d pkts=%0d bytes=%0d",
               $time, err_pulse, e, beat_count, packet_count, byte_count);
      expect_eq("err_pulse", {56'd0, err_pulse}, {56'd0, e});
    end
  end

  task automatic drive(input logic v, input logic r, input logic [31:0] d,
                       input logic [3:0] k, input logic [3:0] s, input logic l,
                       input logic [1:0] id);
    TVALID = v; TREADY = r; TDATA = d; TKEEP = k; TSTRB = s; TLAST = l; TID = id;
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, 32'h0, 4'h0, 4'h0, 1'b0, 2'd0);
  endtask

  // One clock edge with the current inputs; queue the pulse expected after it.
  task automatic step(input logic [7:0] exp);
    @(posedge ACLK);
    exp_q.push_back(exp);
    @(negedge ACLK);
  endtask

  task automatic check_stats(input logic [CW-1:0] beats, input logic [CW-1:0] pkts,
                             input logic [CW-1:0] bytes, input logic [7:0] sticky,
                             input logic inpkt);
    expect_eq("beat_count",   64'(beat_count),   64'(beats));
    expect_eq("packet_count", 64'(packet_count), 64'(pkts));
    expect_eq("byte_count",   64'(byte_count),   64'(bytes));
    expect_eq("err_sticky",   64'(err_sticky),   64'(sticky));
    expect_eq("in_packet",    64'(in_packet),    64'(inpkt));
  endtask

  initial begin
    logic [3:0] kl [4];
    kl = '{4'hF, 4'h3, 4'h1, 4'h7};

    // Reset state
    idle();
    repeat (2) @(negedge ACLK);
    check_stats('0, '0, '0, 8'h00, 1'b0);
    expect_eq("err_pulse_rst", 64'(err_pulse), 64'd0);
    ARESETn = 1'b1;
    step(8'h00);

    // Plain 3-beat packet
    drive(1, 1, 32'hA0, 4'hF, 4'hF, 0, 2'd0); step(8'h00);
    expect_eq("in_packet_b1", 64'(in_packet), 64'd1);
    drive(1, 1, 32'hA1, 4'hF, 4'hF, 0, 2'd0); step(8'h00);
    drive(1, 1, 32'hA2, 4'hF, 4'hF, 1, 2'd0); step(8'h00);
    idle(); step(8'h00);
    check_stats(3, 1, 12, 8'h00, 1'b0);

    // Stall timeout: fires on the 16th stalled edge only
    drive(1, 0, 32'hB0, 4'hF, 4'hF, 0, 2'd0);
    repeat (15) step(8'h00);
    step(8'h08);
    repeat (4) step(8'h00);
    expect_eq("sticky_timeout", 64'(err_sticky), 64'h08);
    drive(1, 1, 32'hB0, 4'hF, 4'hF, 0, 2'd0); step(8'h00);
    drive(1, 1, 32'hB1, 4'hF, 4'hF, 1, 2'd0); step(8'h00);
    idle(); step(8'h00);
    check_stats(5, 2, 20, 8'h08, 1'b0);

    // Payload change under stall, then valid drop under stall
    drive(1, 0, 32'h11, 4'hF, 4'hF, 0, 2'd0); step(8'h00);
    drive(1, 0, 32'h22, 4'hF, 4'hF, 0, 2'd0); step(8'h02);
    drive(1, 1, 32'h22, 4'hF, 4'hF, 0, 2'd0); step(8'h00);
    drive(1, 1, 32'h33, 4'hF, 4'hF, 1, 2'd0); step(8'h00);
    drive(1, 0, 32'h44, 4'hF, 4'hF, 0, 2'd0); step(8'h00);
    idle(); step(8'h01);
    step(8'h00);
    check_stats(7, 3, 28, 8'h0B, 1'b0);

    // Too short: single-beat packet
    drive(1, 1, 32'h55, 4'hF, 4'hF, 1, 2'd0); step(8'h20);
    expect_eq("in_packet_single", 64'(in_packet), 64'd0);

    // Too long: 6 beats, reported once on beat 5
    for (int b = 1; b <= 6; b++) begin
      drive(1, 1, 32'h60 + b, 4'hF, 4'hF, (b == 6), 2'd0);
      step((b == 5) ? 8'h10 : 8'h00);
      expect_eq("in_packet_long", 64'(in_packet), (b != 6) ? 64'd1 : 64'd0);
    end

    // Exactly MAX_PACKET beats with partial TKEEP
    for (int b = 0; b < 4; b++) begin
      drive(1, 1, 32'h70 + b, kl[b], kl[b], (b == 3), 2'd0);
      step(8'h00);
    end
    check_stats(18, 6, 66, 8'h3B, 1'b0);

    // TID switch mid-packet, then TSTRB outside TKEEP on a lone beat (also too short)
    drive(1, 1, 32'h81, 4'hF, 4'hF, 0, 2'd1); step(8'h00);
    drive(1, 1, 32'h82, 4'hF, 4'hF, 1, 2'd2); step(8'h40);
    drive(1, 1, 32'h83, 4'h1, 4'h3, 1, 2'd0); step(8'h24);
    idle(); step(8'h00);
    check_stats(21, 8, 75, 8'h7F, 1'b0);

    // Reset mid-packet, then TVALID high on the first cycle after release
    drive(1, 1, 32'h91, 4'hF, 4'hF, 0, 2'd0); step(8'h00);
    step(8'h00);
    expect_eq("in_packet_pre_rst", 64'(in_packet), 64'd1);
    idle();
    ARESETn = 1'b0;
    #1;
    check_stats('0, '0, '0, 8'h00, 1'b0);
    expect_eq("err_pulse_in_rst", 64'(err_pulse), 64'd0);
    repeat (2) @(negedge ACLK);
    drive(1, 1, 32'hC0, 4'hF, 4'hF, 0, 2'd0);
    ARESETn = 1'b1;
    step(8'h80);
    drive(1, 1, 32'hC1, 4'hF, 4'hF, 1, 2'd0); step(8'h00);
    idle(); step(8'h00);
    check_stats(2, 1, 8, 8'h80, 1'b0);

    repeat (2) @(posedge ACLK);
    #1;
    expect_eq("queue_drained", 64'(exp_q.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
